// File: rtl/segdisp_pkg.sv
// Register map, CTRL field positions and hex glyph table shared by the
// segment display scanner and its decoder.
package segdisp_pkg;

    localparam logic [1:0] SEG_DATA = 2'd0;
    localparam logic [1:0] SEG_CTRL = 2'd1;
    localparam logic [1:0] SEG_STAT = 2'd2;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_LZB    = 1;
    localparam int CTRL_DP_LSB = 8;
    localparam int CTRL_DP_MSB = 15;
    localparam int STAT_EN     = 8;

    // Active-high {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-high {dp,g..a}; a blanked digit keeps its dp.
module seg7_decode
    import segdisp_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = {dp_i, HEX7_TABLE[nibble_i]};
        if (blank_i) begin
            seg_o[6:0] = 7'h00;
        end
    end

endmodule

// File: rtl/ahblite_segdisp_scan.sv
// Zero-wait AHB-Lite slave that scans a multiplexed 7-segment display from
// software-written nibbles, dp mask and enable/blanking controls.
module ahblite_segdisp_scan
    import segdisp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_sel
);

    localparam int   DW    = 4 * NUM_DIGITS;
    localparam int   CNT_W = $clog2(SCAN_DIV);
    localparam logic POL   = (ACTIVE_LOW != 0);

    logic                  dphase_q;
    logic                  wr_q;
    logic [1:0]            addr_q;
    logic [DW-1:0]         data_q;
    logic                  en_q;
    logic                  lzb_q;
    logic [7:0]            dp_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  wr_en;
    logic [DW-1:0]         data_shift;
    logic [3:0]            nibble;
    logic                  blank;
    logic [7:0]            seg_hi;
    logic [NUM_DIGITS-1:0] onehot;
    logic                  unused_ok;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HPROT, HWDATA};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dphase_q <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= 2'd0;
        end else begin
            dphase_q <= HSEL & HTRANS[1] & HREADY;
            wr_q     <= HWRITE;
            addr_q   <= HADDR[3:2];
        end
    end

    assign wr_en = dphase_q & wr_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_q <= '0;
            en_q   <= 1'b0;
            lzb_q  <= 1'b0;
            dp_q   <= 8'h00;
        end else if (wr_en) begin
            case (addr_q)
                SEG_DATA: data_q <= HWDATA[DW-1:0];
                SEG_CTRL: begin
                    en_q  <= HWDATA[CTRL_EN];
                    lzb_q <= HWDATA[CTRL_LZB];
                    dp_q  <= HWDATA[CTRL_DP_MSB:CTRL_DP_LSB];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        HRDATA = 32'h0;
        if (dphase_q && !wr_q) begin
            case (addr_q)
                SEG_DATA: HRDATA[DW-1:0] = data_q;
                SEG_CTRL: begin
                    HRDATA[CTRL_EN]                 = en_q;
                    HRDATA[CTRL_LZB]                = lzb_q;
                    HRDATA[CTRL_DP_MSB:CTRL_DP_LSB] = dp_q;
                end
                SEG_STAT: begin
                    HRDATA[2:0]     = idx_q;
                    HRDATA[STAT_EN] = en_q;
                end
                default: ;
            endcase
        end
    end

    // Disabled scan parks at digit 0 so re-enabling gives digit 0 a full period.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!en_q) begin
            cnt_d = '0;
            idx_d = 3'd0;
        end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        data_shift = data_q >> {idx_q, 2'b00};
        nibble     = data_shift[3:0];
        blank      = lzb_q && (idx_q != 3'd0) && (data_shift == '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            onehot[i] = (idx_q == 3'(i));
        end
    end

    seg7_decode u_decode (
        .nibble_i (nibble),
        .blank_i  (blank),
        .dp_i     (dp_q[idx_q]),
        .seg_o    (seg_hi)
    );

    always_comb begin
        seg_d = {8{POL}};
        dig_d = {NUM_DIGITS{POL}};
        if (en_q) begin
            seg_d = seg_hi ^ {8{POL}};
            dig_d = onehot ^ {NUM_DIGITS{POL}};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
            seg_q <= {8{POL}};
            dig_q <= {NUM_DIGITS{POL}};
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            dig_q <= dig_d;
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_q;

endmodule

// File: tb/tb_ahblite_segdisp_scan.sv
// Scoreboard bench for the AHB-Lite segment display scanner (4 digits,
// 4-cycle scan period, active-low pins).
module tb_ahblite_segdisp_scan;

    localparam int ND = 4;

    logic          HCLK    = 1'b0;
    logic          HRESETn = 1'b0;
    logic          HSEL    = 1'b0;
    logic [31:0]   HADDR   = 32'h0;
    logic [1:0]    HTRANS  = 2'b00;
    logic [2:0]    HSIZE   = 3'b010;
    logic [3:0]    HPROT   = 4'h0;
    logic          HWRITE  = 1'b0;
    logic [31:0]   HWDATA  = 32'h0;
    logic          HREADY  = 1'b1;
    logic          HREADYOUT;
    logic [31:0]   HRDATA;
    logic          HRESP;
    logic [7:0]    seg;
    logic [ND-1:0] dig_sel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string         name;
        logic [7:0]    seg;
        logic [ND-1:0] dig;
    } pin_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } rd_t;

    pin_t pin_q[$];
    rd_t  rd_q[$];

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    ahblite_segdisp_scan #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (4),
        .ACTIVE_LOW (1)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HPROT     (HPROT),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP),
        .seg       (seg),
        .dig_sel   (dig_sel)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // seg_hi is the active-high pattern; digit < 0 means no digit selected.
    task automatic push_pin(input string name, input logic [7:0] seg_hi, input int digit, input int n);
        pin_t          p;
        logic [ND-1:0] oh;
        oh = '0;
        if (digit >= 0) oh[digit] = 1'b1;
        p.name = name;
        p.seg  = ~seg_hi;
        p.dig  = ~oh;
        for (int k = 0; k < n; k++) pin_q.push_back(p);
    endtask

    task automatic push_rd(input string name, input logic [31:0] val);
        rd_t r;
        r.name = name;
        r.val  = val;
        rd_q.push_back(r);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = 1'b1;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        @(negedge HCLK);
        HWDATA = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = 1'b0;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
    endtask

    task automatic test_reset();
        logic [31:0] rdata;
        rd_t         er;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        checks++;
        if ({seg, dig_sel} !== {8'hFF, 4'hF}) begin
            errors++;
            $display("FAIL reset_pins: seg=%h dig_sel=%b, expected seg=ff dig_sel=1111", seg, dig_sel);
        end
        checks++;
        if ({HREADYOUT, HRESP} !== 2'b10) begin
            errors++;
            $display("FAIL tie_offs: HREADYOUT=%b HRESP=%b, expected 1 and 0", HREADYOUT, HRESP);
        end
        bus_write(32'h0, 32'h0000_1234);
        bus_write(32'h4, 32'h0000_0001);
        repeat (6) @(negedge HCLK);
        @(posedge HCLK);
        #3 HRESETn = 1'b0;
        #1;
        checks++;
        if (seg !== 8'hFF) begin
            errors++;
            $display("FAIL async_reset_seg: seg=%h, expected ff", seg);
        end
        checks++;
        if (dig_sel !== 4'hF) begin
            errors++;
            $display("FAIL async_reset_dig: dig_sel=%b, expected 1111", dig_sel);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        push_rd("rst_data", 32'h0);
        push_rd("rst_ctrl", 32'h0);
        push_rd("rst_stat", 32'h0);
        push_rd("rst_unmapped", 32'h0);
        for (int a = 0; a < 4; a++) begin
            bus_read(32'(a * 4), rdata);
            er = rd_q.pop_front();
            checks++;
            if (rdata !== er.val) begin
                errors++;
                $display("FAIL %s: read %h, expected %h", er.name, rdata, er.val);
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [15:0] val;
        pin_t        ep;
        val = 16'h1234;
        bus_write(32'h0, 32'h0000_1234);
        bus_write(32'h4, 32'h0000_0001);
        push_pin("scan_idle", 8'h00, -1, 1);
        for (int d = 0; d < 5; d++) begin
            push_pin($sformatf("scan_digit%0d", d % 4), {1'b0, glyph[val[4*(d%4) +: 4]]}, d % 4, 4);
        end
        while (pin_q.size() > 0) begin
            ep = pin_q.pop_front();
            checks++;
            if ({seg, dig_sel} !== {ep.seg, ep.dig}) begin
                errors++;
                $display("FAIL %s: seg=%h dig_sel=%b, expected seg=%h dig_sel=%b", ep.name, seg, dig_sel, ep.seg, ep.dig);
            end
            @(negedge HCLK);
        end
    endtask

    task automatic test_lzb_dp();
        logic [31:0] rdata;
        rd_t         er;
        pin_t        ep;
        bus_write(32'h4, 32'h0000_0000);
        bus_write(32'h0, 32'h0000_0005);
        bus_write(32'h4, 32'h0000_0203);
        push_pin("lzb_idle", 8'h00, -1, 1);
        push_pin("lzb_digit0", 8'h6D, 0, 4);
        push_pin("lzb_digit1_dp", 8'h80, 1, 4);
        push_pin("lzb_digit2_blank", 8'h00, 2, 4);
        push_pin("lzb_digit3_blank", 8'h00, 3, 4);
        while (pin_q.size() > 0) begin
            ep = pin_q.pop_front();
            checks++;
            if ({seg, dig_sel} !== {ep.seg, ep.dig}) begin
                errors++;
                $display("FAIL %s: seg=%h dig_sel=%b, expected seg=%h dig_sel=%b", ep.name, seg, dig_sel, ep.seg, ep.dig);
            end
            @(negedge HCLK);
        end
        push_rd("lzb_ctrl_read", 32'h0000_0203);
        bus_read(32'h4, rdata);
        er = rd_q.pop_front();
        checks++;
        if (rdata !== er.val) begin
            errors++;
            $display("FAIL %s: read %h, expected %h", er.name, rdata, er.val);
        end
    endtask

    task automatic test_disable();
        logic [31:0] rdata;
        rd_t         er;
        pin_t        ep;
        bit          found;
        bus_write(32'h4, 32'h0000_0000);
        bus_write(32'h0, 32'h0000_1234);
        bus_write(32'h4, 32'h0000_0001);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge HCLK);
            if (dig_sel === 4'b1011) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL disable_wait_digit2: dig_sel never reached 1011 within 40 cycles, last %b", dig_sel);
        end
        bus_write(32'h4, 32'h0000_0000);
        @(negedge HCLK);
        checks++;
        if ({seg, dig_sel} !== {8'hFF, 4'hF}) begin
            errors++;
            $display("FAIL disable_pins: seg=%h dig_sel=%b, expected seg=ff dig_sel=1111", seg, dig_sel);
        end
        push_rd("disable_status", 32'h0);
        bus_read(32'h8, rdata);
        er = rd_q.pop_front();
        checks++;
        if (rdata !== er.val) begin
            errors++;
            $display("FAIL %s: read %h, expected %h", er.name, rdata, er.val);
        end
        bus_write(32'h4, 32'h0000_0001);
        push_pin("reen_idle", 8'h00, -1, 1);
        push_pin("reen_digit0", {1'b0, glyph[4]}, 0, 4);
        push_pin("reen_digit1", {1'b0, glyph[3]}, 1, 1);
        while (pin_q.size() > 0) begin
            ep = pin_q.pop_front();
            checks++;
            if ({seg, dig_sel} !== {ep.seg, ep.dig}) begin
                errors++;
                $display("FAIL %s: seg=%h dig_sel=%b, expected seg=%h dig_sel=%b", ep.name, seg, dig_sel, ep.seg, ep.dig);
            end
            @(negedge HCLK);
        end
    endtask

    task automatic test_simultaneous();
        pin_t ep;
        bus_write(32'h4, 32'h0000_0000);
        bus_write(32'h0, 32'h0000_1234);
        bus_write(32'h4, 32'h0000_0001);
        // Aligns the DATA write's data phase with the first terminal count.
        @(negedge HCLK);
        bus_write(32'h0, 32'h0000_00A0);
        push_pin("simul_old_digit0", {1'b0, glyph[4]}, 0, 1);
        push_pin("simul_new_digit1", {1'b0, glyph[10]}, 1, 4);
        push_pin("simul_zero_digit2", {1'b0, glyph[0]}, 2, 1);
        while (pin_q.size() > 0) begin
            ep = pin_q.pop_front();
            checks++;
            if ({seg, dig_sel} !== {ep.seg, ep.dig}) begin
                errors++;
                $display("FAIL %s: seg=%h dig_sel=%b, expected seg=%h dig_sel=%b", ep.name, seg, dig_sel, ep.seg, ep.dig);
            end
            @(negedge HCLK);
        end
    endtask

    task automatic test_readback();
        logic [31:0] rdata;
        rd_t         er;
        bus_write(32'h4, 32'h0000_0000);
        bus_write(32'h0, 32'hFFFF_FFFF);
        bus_write(32'hC, 32'h1234_5678);
        push_rd("rb_data_trunc", 32'h0000_FFFF);
        push_rd("rb_unmapped", 32'h0);
        push_rd("rb_data_after_unmapped", 32'h0000_FFFF);
        bus_read(32'h0, rdata);
        er = rd_q.pop_front();
        checks++;
        if (rdata !== er.val) begin
            errors++;
            $display("FAIL %s: read %h, expected %h", er.name, rdata, er.val);
        end
        bus_read(32'hC, rdata);
        er = rd_q.pop_front();
        checks++;
        if (rdata !== er.val) begin
            errors++;
            $display("FAIL %s: read %h, expected %h", er.name, rdata, er.val);
        end
        bus_read(32'h0, rdata);
        er = rd_q.pop_front();
        checks++;
        if (rdata !== er.val) begin
            errors++;
            $display("FAIL %s: read %h, expected %h", er.name, rdata, er.val);
        end
        bus_write(32'h4, 32'hFFFF_FFFF);
        push_rd("rb_ctrl_mask", 32'h0000_FF03);
        bus_read(32'h4, rdata);
        er = rd_q.pop_front();
        checks++;
        if (rdata !== er.val) begin
            errors++;
            $display("FAIL %s: read %h, expected %h", er.name, rdata, er.val);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rdata;
        rd_t         er;
        push_rd("b2b_ctrl", 32'h0000_0502);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4; HWRITE = 1'b1;
        @(negedge HCLK);
        HWDATA = 32'h0000_0502; HADDR = 32'h4; HWRITE = 1'b0;
        checks++;
        if ({HREADYOUT, HRDATA} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL b2b_write_phase: HREADYOUT=%b HRDATA=%h, expected 1 and 00000000", HREADYOUT, HRDATA);
        end
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0;
        rdata = HRDATA;
        er = rd_q.pop_front();
        checks++;
        if (rdata !== er.val || HREADYOUT !== 1'b1) begin
            errors++;
            $display("FAIL %s: read %h ready %b, expected %h ready 1", er.name, rdata, HREADYOUT, er.val);
        end
        @(negedge HCLK);
        checks++;
        if ({seg, dig_sel, HRDATA} !== {8'hFF, 4'hF, 32'h0}) begin
            errors++;
            $display("FAIL b2b_idle_after_disable: seg=%h dig_sel=%b HRDATA=%h, expected ff 1111 00000000", seg, dig_sel, HRDATA);
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_lzb_dp();
        test_disable();
        test_simultaneous();
        test_readback();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahblite_segdisp_scan.md
Name: ahblite_segdisp_scan

Overview:
AHB-Lite slave driving a multiplexed, multi-digit 7-segment display (a–g plus dp). Software writes hex nibbles, a decimal-point mask and control bits. The block decodes each nibble and scans the digits round-robin at a programmable rate, so the pins need no CPU involvement. It sits on the AHB-Lite peripheral bus as a zero-wait-state slave.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
SCAN_DIV, 50000, HCLK cycles each digit stays lit; legal range 2..2^20.
ACTIVE_LOW, 1, 1 = seg and dig_sel pins active-low (common-anode board); 0 = active-high.

Ports:
HCLK  in  1  bus and core clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  32  address; only [3:2] decoded
HTRANS  in  2  transfer type; active when HTRANS[1]=1
HSIZE  in  3  ignored; all writes are full-word
HPROT  in  4  ignored
HWRITE  in  1  1 = write
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus ready
HREADYOUT  out  1  tied 1
HRDATA  out  32  read data
HRESP  out  1  tied 0 (OKAY)
seg  out  8  {dp,g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
dig_sel  out  NUM_DIGITS  one-hot digit enable, polarity per ACTIVE_LOW

Behaviour:
- Clocking and reset: one clock, HCLK. HRESETn is asynchronous, active-low.
- Reset values: all registers 0; seg and dig_sel at their inactive level (all 1s if ACTIVE_LOW, else 0s); digit index 0; prescaler 0.
- Address phase: when HSEL & HTRANS[1] & HREADY, register HADDR[3:2] and HWRITE.
- Write: performed in the data phase from HWDATA; visible on register readback the next cycle.
- Register map:
  - 0x0 DATA: nibble i = bits [4i+3:4i] drives digit i. Bits at and above 4*NUM_DIGITS read 0 and are not stored.
  - 0x4 CTRL: [0] EN; [1] LZB (leading-zero blank); [15:8] DP mask, bit 8+i lights the dp of digit i. Unimplemented bits read 0.
  - 0x8 STATUS (read-only): [2:0] current digit index; [8] EN.
  - 0xC: reads 0; writes ignored.
- Read data: combinational from the registered data-phase address. HRDATA = 0 outside a registered read.
- Prescaler: when EN=1, counts 0..SCAN_DIV-1. At terminal count it returns to 0 and the digit index advances, wrapping from NUM_DIGITS-1 to 0.
- Disable: when EN=0, the prescaler and index are held at 0 and seg/dig_sel are driven inactive on the next cycle. Clearing EN mid-scan takes effect immediately. Re-enabling restarts at digit 0 with a full SCAN_DIV period.
- Pin outputs: seg and dig_sel are registered, with one cycle of latency from the index or register change.
  - dig_sel activates only the current index.
  - seg = hex7(nibble[index]) with dp = mask[index].
- Hex decode: standard 0–9, A, b, C, d, E, F glyphs (active-high before polarity is applied):
  0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Leading-zero blanking: with LZB=1, digit i (i>0) is blanked when its nibble and all higher nibbles are 0. Digit 0 is never blanked. dp still follows the mask on a blanked digit.
- Simultaneous write and scan tick: both take effect. The next seg value uses the new data and the new index.

Decomposition:
- Package segdisp_pkg holds:
  - register offsets (SEG_DATA, SEG_CTRL, SEG_STAT);
  - CTRL bit positions;
  - the 16-entry hex-to-7seg constant table.
- One sub-module, seg7_decode: combinational nibble + blank + dp to 8-bit active-high segments. Polarity inversion stays in the top level.

Test Plan:
- Reset: NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1, assert HRESETn low mid-cycle -> seg=8'hFF and dig_sel=4'hF immediately; all registers read 0.
- Basic scan: write DATA=0x1234, CTRL=0x1 -> dig_sel cycles 1110, 1101, 1011, 0111, each held 4 cycles, with seg=~8'h66, ~8'h4F, ~8'h5B, ~8'h06 respectively; pattern wraps to digit 0.
- Leading-zero blanking and dp: DATA=0x0005, CTRL=0x0203 -> digits 3 and 2 show seg=8'hFF; digit 1 shows ~8'h80 (dp only); digit 0 shows ~8'h6D.
- Disable mid-scan: clear EN while digit 2 is lit -> next cycle dig_sel=4'hF, STATUS[2:0]=0; re-enable -> digit 0 lights for a full 4 cycles.
- Readback and unmapped: write DATA=0xFFFFFFFF with NUM_DIGITS=4 -> reads 0x0000FFFF; write 0xC -> no effect, reads 0; back-to-back write/read to CTRL returns the new value with zero wait states.
- Simultaneous event: write DATA on the same cycle as a prescaler terminal count -> next seg reflects the new nibble at the new index.
